fft16_frame_ctrl: RTL and testbench
===================================

Name: fft16_frame_ctrl

Overview:
Frame sequencer for the 16-point FFT core and its 16-entry complex register bank. It collects a serial stream of 16 complex samples into a frame and presents them in parallel to the FFT datapath. It then pulses start, waits the fixed core latency and captures the 16 results. It streams the results out serially with valid/ready, optionally in bit-reversed slot order.

Parameters:
N, 16, bit width of each real/imag component
FFT_LAT, 4, cycles from fft_start to valid fft_out_flat; legal range 1..255
BIT_REV, 0, 1 = output bin k is taken from captured slot bitrev4(k); 0 = from slot k

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  reset; synchronous, active-high
s_valid  in  1  input sample valid
s_ready  out  1  controller accepts input sample
s_re  in  N  input sample real part
s_im  in  N  input sample imaginary part
fft_in_flat  out  32*N  frame to FFT; slot k re at [2kN +: N], im at [(2k+1)N +: N]
fft_start  out  1  one-cycle pulse; frame on fft_in_flat is complete
fft_out_flat  in  32*N  FFT results, same packing as fft_in_flat
m_valid  out  1  output bin valid
m_ready  in  1  downstream accepts bin
m_re  out  N  output bin real part
m_im  out  N  output bin imaginary part
m_index  out  4  bin number k of the current output
m_last  out  1  high with bin 15
busy  out  1  high in WAIT and DRAIN

Behaviour:
- FSM states: FILL, WAIT, DRAIN. Reset enters FILL.
- Reset values: in_cnt=0, out_idx=0, lat_cnt=0, input and result buffers all 0, fft_start=0, m_valid=0, m_index=0, m_last=0, busy=0, s_ready=1 (FILL).
- Reset mid-operation discards the partial frame and any undrained results. No m_valid is issued for the discarded frame.
- FILL: s_ready=1.
  - On s_valid&&s_ready, write {s_re,s_im} to slot in_cnt and increment in_cnt.
  - Accepting slot 15 moves the FSM to WAIT next cycle and wraps in_cnt to 0.
  - s_valid without a handshake has no effect.
- WAIT: s_ready=0.
  - fft_start=1 only in the first WAIT cycle (cycle T); lat_cnt is loaded with FFT_LAT at that edge.
  - lat_cnt decrements each cycle.
  - At the edge ending cycle T+FFT_LAT, fft_out_flat is captured into the result buffer and the FSM moves to DRAIN.
- fft_in_flat holds its value from the slot-15 accept until the next FILL write; it never changes during WAIT.
- DRAIN: m_valid=1; m_index=out_idx.
  - m_re/m_im come from result slot out_idx, or slot bitrev4(out_idx) when BIT_REV=1.
  - m_last=(out_idx==15).
  - Outputs are held stable while m_valid&&!m_ready.
  - On m_valid&&m_ready, out_idx increments.
  - The handshake on bin 15 returns the FSM to FILL and wraps out_idx to 0; m_valid drops the next cycle.
- s_ready=0 throughout WAIT and DRAIN. No input/output overlap; the next frame starts only after bin 15 is accepted.
- Latency: fft_start asserts 1 cycle after the slot-15 accept. m_valid for bin 0 asserts FFT_LAT+1 cycles after fft_start.
- Minimum frame period with continuous valid/ready: 16 + 1 + FFT_LAT + 16 cycles.
- All data is passed through unmodified; no arithmetic or width change.

Test Plan:
- Bench FFT stub: a registered pass-through with FFT_LAT=1 and BIT_REV=0.
  - Stimulus: continuous samples re=k*100, im=-k for k=0..15, m_ready=1.
  - Required: fft_start pulses once, 1 cycle after the 16th accept; m_valid rises 2 cycles after fft_start; bins 0..15 appear in order with re=k*100, im=-k; m_last only on bin 15; s_ready returns high the cycle after.
- Same stub with BIT_REV=1, sending re=k.
  - Required: output sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with m_index 0..15.
- Backpressure: drive m_ready with a pattern low for 3 cycles, high for 1 cycle.
  - Required: m_re/m_im/m_index stay unchanged while stalled; no bin is lost or duplicated; exactly 16 handshakes occur.
- Gapped input: s_valid toggles every other cycle; also drive s_valid=1 during WAIT/DRAIN.
  - Required: only 16 accepts per frame; extra words are not consumed (s_ready=0); fft_in_flat is unchanged during WAIT.
- FFT_LAT=7: stub delays data by 7 cycles and drives X before that.
  - Required: captured values are correct, so the capture happens exactly at cycle T+7.
- Reset mid-frame: assert i_rst after 9 accepts, then for 1 cycle during DRAIN at bin 5.
  - Required: all outputs return to their reset values next cycle, s_ready=1, and no m_valid appears until a fresh full frame of 16 samples completes.

Source files
------------

// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer for the 16-point FFT core: serial fill, parallel hand-off,
// fixed-latency capture, then serial drain with optional bit-reversed slot order.
module fft16_frame_ctrl #(
    parameter int N       = 16,
    parameter int FFT_LAT = 4,
    parameter bit BIT_REV = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [N-1:0]    s_re,
    input  logic [N-1:0]    s_im,
    output logic [32*N-1:0] fft_in_flat,
    output logic            fft_start,
    input  logic [32*N-1:0] fft_out_flat,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [N-1:0]    m_re,
    output logic [N-1:0]    m_im,
    output logic [3:0]      m_index,
    output logic            m_last,
    output logic            busy
);
    localparam int SLOTS = 16;

    typedef enum logic [1:0] {FILL, WAIT, DRAIN} state_t;

    state_t                     state, state_nxt;
    logic [3:0]                 in_cnt, out_idx, rd_slot;
    logic [7:0]                 lat_cnt;
    logic [SLOTS-1:0][2*N-1:0]  in_buf, res_buf;
    logic                       in_fire, out_fire, lat_done;

    assign in_fire  = s_valid && (state == FILL);
    assign out_fire = m_ready && (state == DRAIN);
    // lat_cnt is 0 on the start cycle, so reaching 1 marks cycle T+FFT_LAT
    assign lat_done = (state == WAIT) && (lat_cnt == 8'd1);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= FILL;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        fft_start = 1'b0;
        m_valid   = 1'b0;
        busy      = 1'b0;
        case (state)
            FILL: begin
                s_ready = 1'b1;
                if (s_valid && (in_cnt == 4'd15)) state_nxt = WAIT;
            end
            WAIT: begin
                busy      = 1'b1;
                fft_start = (lat_cnt == 8'd0);
                if (lat_done) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                if (m_ready && (out_idx == 4'd15)) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            in_cnt  <= '0;
            out_idx <= '0;
            lat_cnt <= '0;
        end else begin
            if (in_fire)  in_cnt  <= in_cnt + 4'd1;
            if (out_fire) out_idx <= out_idx + 4'd1;
            if (fft_start)            lat_cnt <= 8'(FFT_LAT);
            else if (lat_cnt != 8'd0) lat_cnt <= lat_cnt - 8'd1;
        end
    end

    // Per-slot storage; each entry packs {im, re} so the bank maps 1:1 onto the flat bus
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            in_buf  <= '0;
            res_buf <= '0;
        end else begin
            for (int k = 0; k < SLOTS; k++) begin
                if (in_fire && (in_cnt == 4'(k))) in_buf[k] <= {s_im, s_re};
                if (lat_done) res_buf[k] <= fft_out_flat[2*k*N +: 2*N];
            end
        end
    end

    assign fft_in_flat = in_buf;
    assign rd_slot     = BIT_REV ? {out_idx[0], out_idx[1], out_idx[2], out_idx[3]} : out_idx;
    assign m_re        = res_buf[rd_slot][N-1:0];
    assign m_im        = res_buf[rd_slot][2*N-1:N];
    assign m_index     = out_idx;
    assign m_last      = (state == DRAIN) && (out_idx == 4'd15);

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Directed bench for fft16_frame_ctrl: three instances (LAT=1, LAT=1 bit-reversed,
// LAT=7 with X-until-valid stub), each driven through its own port set.
module tb_fft16_frame_ctrl;
    localparam int N = 16;
    localparam int W = 32 * N;
    localparam int EXP_BR [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         s_valid [3];
    logic         s_ready [3];
    logic [N-1:0] s_re    [3];
    logic [N-1:0] s_im    [3];
    logic [W-1:0] fin     [3];
    logic [W-1:0] fout    [3];
    logic         fst     [3];
    logic         mv      [3];
    logic         mr      [3];
    logic [N-1:0] mre     [3];
    logic [N-1:0] mim     [3];
    logic [3:0]   midx    [3];
    logic         mlast   [3];
    logic         busy    [3];

    int tests = 0;
    int fails = 0;
    int st_cnt [3] = '{0, 0, 0};

    logic [N-1:0] c_re [16];
    logic [N-1:0] c_im [16];
    logic [3:0]   c_ix [16];
    logic         c_last [16];
    int c_n, c_first, c_st;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fft16_frame_ctrl #(.N(N), .FFT_LAT(g == 2 ? 7 : 1), .BIT_REV(g == 1)) u_dut (
            .i_clk(clk), .i_rst(rst),
            .s_valid(s_valid[g]), .s_ready(s_ready[g]), .s_re(s_re[g]), .s_im(s_im[g]),
            .fft_in_flat(fin[g]), .fft_start(fst[g]), .fft_out_flat(fout[g]),
            .m_valid(mv[g]), .m_ready(mr[g]), .m_re(mre[g]), .m_im(mim[g]),
            .m_index(midx[g]), .m_last(mlast[g]), .busy(busy[g])
        );
        if (g == 2) begin : g_stub7
            logic [W-1:0] dl [7];
            logic [6:0]   vp = '0;
            always @(posedge clk) begin
                dl[0] <= fin[g];
                for (int i = 1; i < 7; i++) dl[i] <= dl[i-1];
                vp <= {vp[5:0], fst[g] === 1'b1};
            end
            assign fout[g] = vp[6] ? dl[6] : 'x;
        end else begin : g_stub1
            logic [W-1:0] r;
            always @(posedge clk) r <= fin[g];
            assign fout[g] = r;
        end
    end

    always @(posedge clk)
        for (int i = 0; i < 3; i++)
            if (fst[i] === 1'b1) st_cnt[i] <= st_cnt[i] + 1;

    function automatic logic [N-1:0] pre(input int kind, input int k);
        case (kind)
            0: return N'(k * 100);
            1: return N'(k);
            2: return N'(k * 3 + 1);
            3: return N'(16'h0500 + k);
            4: return N'(16'h7000 + k * 7);
            default: return N'(k * 11 + 2);
        endcase
    endfunction

    function automatic logic [N-1:0] pim(input int kind, input int k);
        case (kind)
            0: return N'(-k);
            1: return '0;
            2: return N'(k << 4);
            3: return N'(~k);
            4: return N'(k);
            default: return N'(16'h1234 ^ k);
        endcase
    endfunction

    // Stimulus: push cnt samples of pattern `kind`; returns aligned just after the last accept edge
    task automatic send_frame(input int d, input int kind, input bit gap, input bit keep, input int cnt);
        int k = 0;
        for (int cyc = 0; cyc < 400 && k < cnt; cyc++) begin
            s_valid[d] = gap ? (cyc % 2 == 0) : 1'b1;
            s_re[d]    = s_valid[d] ? pre(kind, k) : 16'hffff;
            s_im[d]    = s_valid[d] ? pim(kind, k) : 16'hffff;
            @(negedge clk);
            if (s_valid[d] && s_ready[d]) k++;
            @(posedge clk); #1;
        end
        tests++;
        if (k != cnt) begin
            fails++;
            $display("FAIL send_timeout dut%0d: accepted %0d want %0d", d, k, cnt);
        end
        s_valid[d] = keep;
        s_re[d]    = 16'hdead;
        s_im[d]    = 16'hbeef;
    endtask

    // Stimulus: drain with m_ready=1, recording bins and the cycles of fft_start / first m_valid
    task automatic collect(input int d);
        c_n = 0; c_first = -1; c_st = -1;
        for (int i = 0; i < 16; i++) begin
            c_re[i] = 'x; c_im[i] = 'x; c_ix[i] = 'x; c_last[i] = 1'bx;
        end
        mr[d] = 1'b1;
        for (int c = 0; c < 300 && c_n < 16; c++) begin
            @(negedge clk);
            if (fst[d] === 1'b1 && c_st < 0) c_st = c;
            if (mv[d] === 1'b1) begin
                if (c_first < 0) c_first = c;
                c_re[c_n] = mre[d]; c_im[c_n] = mim[d];
                c_ix[c_n] = midx[d]; c_last[c_n] = mlast[d];
                c_n++;
            end
            @(posedge clk); #1;
        end
        mr[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({s_ready[0], mv[0], fst[0], busy[0], mlast[0], midx[0]} !== 9'b1_0000_0000) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 100000000",
                     {s_ready[0], mv[0], fst[0], busy[0], mlast[0], midx[0]});
        end
        tests++;
        if (fin[0] !== '0) begin
            fails++;
            $display("FAIL reset_fin: got %h want 0", fin[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int s0 = st_cnt[0];
        send_frame(0, 0, 1'b0, 1'b0, 16);
        collect(0);
        tests++;
        if (c_st != 0) begin
            fails++; $display("FAIL basic_start_cycle: got %0d want 0", c_st);
        end
        tests++;
        if (c_first - c_st != 2) begin
            fails++; $display("FAIL basic_mvalid_latency: got %0d want 2", c_first - c_st);
        end
        tests++;
        if (st_cnt[0] - s0 != 1) begin
            fails++; $display("FAIL basic_start_pulses: got %0d want 1", st_cnt[0] - s0);
        end
        for (int k = 0; k < 16; k++) begin
            tests++;
            if ({c_ix[k], c_re[k], c_im[k], c_last[k]} !== {4'(k), pre(0, k), pim(0, k), k == 15}) begin
                fails++;
                $display("FAIL basic_bin%0d: got idx=%0d re=%h im=%h last=%b want idx=%0d re=%h im=%h last=%b",
                         k, c_ix[k], c_re[k], c_im[k], c_last[k], k, pre(0, k), pim(0, k), k == 15);
            end
        end
        @(negedge clk);
        tests++;
        if ({s_ready[0], mv[0]} !== 2'b10) begin
            fails++; $display("FAIL basic_return_fill: got s_ready,m_valid=%b want 10", {s_ready[0], mv[0]});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bitrev();
        send_frame(1, 1, 1'b0, 1'b0, 16);
        collect(1);
        tests++;
        if (c_first - c_st != 2) begin
            fails++; $display("FAIL bitrev_latency: got %0d want 2", c_first - c_st);
        end
        for (int k = 0; k < 16; k++) begin
            tests++;
            if ({c_ix[k], c_re[k]} !== {4'(k), N'(EXP_BR[k])}) begin
                fails++;
                $display("FAIL bitrev_bin%0d: got idx=%0d re=%0d want idx=%0d re=%0d",
                         k, c_ix[k], c_re[k], k, EXP_BR[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int hs = 0;
        int bad = 0;
        send_frame(0, 3, 1'b0, 1'b0, 16);
        for (int c = 0; c < 300 && hs < 16; c++) begin
            mr[0] = (c % 4 == 3);
            @(negedge clk);
            if (mv[0] === 1'b1) begin
                tests++;
                if ({midx[0], mre[0], mim[0]} !== {4'(hs), pre(3, hs), pim(3, hs)}) begin
                    fails++;
                    $display("FAIL bp_bin c=%0d: got idx=%0d re=%h im=%h want idx=%0d re=%h im=%h",
                             c, midx[0], mre[0], mim[0], hs, pre(3, hs), pim(3, hs));
                end
                if (mr[0]) hs++;
            end
            @(posedge clk); #1;
        end
        tests++;
        if (hs != 16) begin
            fails++; $display("FAIL bp_handshakes: got %0d want 16", hs);
        end
        mr[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (mv[0] !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        mr[0] = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL bp_extra_bins: got %0d valid cycles want 0", bad);
        end
    endtask

    task automatic test_gapped();
        logic [W-1:0] exp_fin;
        int hs = 0;
        bit done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_fin[2*k*N +: N]     = pre(4, k);
            exp_fin[(2*k+1)*N +: N] = pim(4, k);
        end
        send_frame(0, 4, 1'b1, 1'b1, 16);
        for (int c = 0; c < 300 && !done; c++) begin
            mr[0] = 1'b1;
            @(negedge clk);
            if (busy[0] === 1'b1) begin
                tests++;
                if (s_ready[0] !== 1'b0) begin
                    fails++; $display("FAIL gap_sready_busy c=%0d: got %b want 0", c, s_ready[0]);
                end
                tests++;
                if (fin[0] !== exp_fin) begin
                    fails++; $display("FAIL gap_fin_hold c=%0d: got %h want %h", c, fin[0], exp_fin);
                end
            end
            if (mv[0] === 1'b1) begin
                tests++;
                if ({midx[0], mre[0], mim[0]} !== {4'(hs), pre(4, hs), pim(4, hs)}) begin
                    fails++;
                    $display("FAIL gap_bin%0d: got idx=%0d re=%h im=%h want re=%h im=%h",
                             hs, midx[0], mre[0], mim[0], pre(4, hs), pim(4, hs));
                end
                hs++;
                if (mlast[0] === 1'b1) done = 1'b1;
            end
            @(posedge clk); #1;
        end
        s_valid[0] = 1'b0;
        mr[0]      = 1'b0;
        @(negedge clk);
        tests++;
        if ({s_ready[0], mv[0], 5'(hs)} !== {2'b10, 5'd16}) begin
            fails++; $display("FAIL gap_end: got s_ready=%b m_valid=%b bins=%0d want 1 0 16", s_ready[0], mv[0], hs);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lat7();
        send_frame(2, 5, 1'b0, 1'b0, 16);
        collect(2);
        tests++;
        if ({c_st, c_first} != {32'd0, 32'd8}) begin
            fails++; $display("FAIL lat7_timing: got start=%0d first=%0d want 0 8", c_st, c_first);
        end
        for (int k = 0; k < 16; k++) begin
            tests++;
            if ({c_ix[k], c_re[k], c_im[k]} !== {4'(k), pre(5, k), pim(5, k)}) begin
                fails++;
                $display("FAIL lat7_bin%0d: got re=%h im=%h want re=%h im=%h",
                         k, c_re[k], c_im[k], pre(5, k), pim(5, k));
            end
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        int bad;
        bit found = 1'b0;
        send_frame(0, 2, 1'b0, 1'b0, 9);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({s_ready[0], mv[0], fst[0], busy[0], mlast[0], midx[0]} !== 9'b1_0000_0000 || fin[0] !== '0) begin
            fails++;
            $display("FAIL rst_fill_outputs: got %b fin_zero=%b want 100000000 1",
                     {s_ready[0], mv[0], fst[0], busy[0], mlast[0], midx[0]}, fin[0] === '0);
        end
        @(posedge clk); #1;
        s0 = st_cnt[0];
        send_frame(0, 2, 1'b0, 1'b0, 16);
        tests++;
        if (st_cnt[0] != s0) begin
            fails++; $display("FAIL rst_fill_early_start: got %0d starts want 0", st_cnt[0] - s0);
        end
        mr[0] = 1'b1;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (mv[0] === 1'b1 && midx[0] == 4'd4) found = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({mv[0], midx[0], mre[0]} !== {1'b1, 4'd5, pre(2, 5)}) begin
            fails++; $display("FAIL rst_drain_bin5: got mv=%b idx=%0d re=%h want 1 5 %h", mv[0], midx[0], mre[0], pre(2, 5));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        mr[0] = 1'b0;
        @(negedge clk);
        tests++;
        if ({s_ready[0], mv[0], fst[0], busy[0], mlast[0], midx[0]} !== 9'b1_0000_0000 || fin[0] !== '0) begin
            fails++;
            $display("FAIL rst_drain_outputs: got %b fin_zero=%b want 100000000 1",
                     {s_ready[0], mv[0], fst[0], busy[0], mlast[0], midx[0]}, fin[0] === '0);
        end
        @(posedge clk); #1;
        bad = 0;
        mr[0] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (mv[0] !== 1'b0 || fst[0] !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        mr[0] = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL rst_idle_quiet: got %0d active cycles want 0", bad);
        end
        send_frame(0, 0, 1'b0, 1'b0, 16);
        collect(0);
        bad = 0;
        for (int k = 0; k < 16; k++)
            if ({c_ix[k], c_re[k], c_im[k]} !== {4'(k), pre(0, k), pim(0, k)}) bad++;
        tests++;
        if ({c_st, c_n, bad} != {32'd0, 32'd16, 32'd0}) begin
            fails++; $display("FAIL rst_fresh_frame: got start=%0d bins=%0d badbins=%0d want 0 16 0", c_st, c_n, bad);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_valid[i] = 1'b0; s_re[i] = '0; s_im[i] = '0; mr[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_bitrev();
        test_backpressure();
        test_gapped();
        test_lat7();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end
endmodule
